// File: rtl/panel_input_if.sv
`default_nettype none
// ============================================================================
// Module      : panel_input_if
// Description : Front-panel signal bundle: raw buttons/switches in, clean
//               debounced levels and one-cycle event pulses out.
// Revision    : 1.0  initial release
// ============================================================================
interface panel_input_if;
    logic [4:0]  BTN;         // raw buttons {U,L,C,R,D}, async, bouncy
    logic [15:0] SW;          // raw slide switches, async, bouncy
    logic [4:0]  BTN_LEVEL;   // debounced button levels
    logic [4:0]  BTN_CLICK;   // one pulse per accepted press
    logic [4:0]  BTN_REPEAT;  // click pulse plus auto-repeat while held
    logic [15:0] SW_STATE;    // debounced switch levels
    logic        SW_CHANGE;   // one pulse per edge where any switch moves

    // Board / stimulus side: drives raw inputs, consumes events
    modport master (
        output BTN, SW,
        input  BTN_LEVEL, BTN_CLICK, BTN_REPEAT, SW_STATE, SW_CHANGE
    );

    // Conditioner side
    modport slave (
        input  BTN, SW,
        output BTN_LEVEL, BTN_CLICK, BTN_REPEAT, SW_STATE, SW_CHANGE
    );
endinterface
`default_nettype wire

// File: rtl/panel_input.sv
`default_nettype none
// ============================================================================
// Module      : panel_input
// Description : Synchronises and debounces 5 push buttons and 16 slide
//               switches; emits click, auto-repeat and switch-change pulses.
// Revision    : 1.0  initial release
// ============================================================================
module panel_input #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  wire logic     CLK,
    input  wire logic     RSTN,
    panel_input_if.slave  pin
);

    localparam int N_BTN = 5;
    localparam int N_SW  = 16;
    localparam int N_IN  = N_BTN + N_SW;

    // Debounce counter only has to reach DEBOUNCE_CYCLES-1
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // One counter width covers both the delay and the period phases
    localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RC_W   = (RC_MAX > 1) ? $clog2(RC_MAX) : 1;
    localparam logic [RC_W-1:0] RD_LAST = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0] RP_LAST = RC_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_PERIOD = 2'd2
    } rep_state_t;

    // Buttons occupy the low bits so button index == vector index
    logic [N_IN-1:0] raw_w;
    assign raw_w = {pin.SW, pin.BTN};

    // ------------------------------------------------------------------
    // Synchroniser chain; the debouncers only ever see the last stage
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][N_IN-1:0] sync_q;
    logic [SYNC_STAGES-1:0][N_IN-1:0] sync_d;

    // Shift raw inputs one stage further each cycle
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw_w};
    end

    // Synchroniser flops
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) sync_q <= '0;
        else       sync_q <= sync_d;
    end

    logic [N_IN-1:0] sync_last_w;
    assign sync_last_w = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Per-input debouncers. stable_now is the registered clean level,
    // stable_next the value it takes at the coming edge; downstream
    // event logic compares the two so pulses line up with the level.
    // ------------------------------------------------------------------
    logic [N_IN-1:0] stable_now_w;
    logic [N_IN-1:0] stable_next_w;

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_deb
        logic            stable_q, stable_d;
        logic [DB_W-1:0] cnt_q, cnt_d;

        // Count consecutive disagreeing cycles; accept after the full window
        always_comb begin
            stable_d = stable_q;
            cnt_d    = cnt_q;
            if (sync_last_w[gi] == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == DB_LAST) begin
                stable_d = sync_last_w[gi];
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Debounce state flops
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                stable_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                stable_q <= stable_d;
                cnt_q    <= cnt_d;
            end
        end

        assign stable_now_w[gi]  = stable_q;
        assign stable_next_w[gi] = stable_d;
    end

    logic [N_BTN-1:0] lvl_now_w, lvl_next_w;
    logic [N_SW-1:0]  sw_now_w,  sw_next_w;
    assign lvl_now_w  = stable_now_w[N_BTN-1:0];
    assign lvl_next_w = stable_next_w[N_BTN-1:0];
    assign sw_now_w   = stable_now_w[N_IN-1:N_BTN];
    assign sw_next_w  = stable_next_w[N_IN-1:N_BTN];

    // ------------------------------------------------------------------
    // Click and switch-change pulses, registered so they coincide with
    // the first cycle the new debounced level is visible
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] click_q, click_d;
    logic             change_q, change_d;

    // Detect rising button levels and any switch movement at this edge
    always_comb begin
        click_d  = lvl_next_w & ~lvl_now_w;
        change_d = |(sw_next_w ^ sw_now_w);
    end

    // Event pulse flops
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            click_q  <= '0;
            change_q <= 1'b0;
        end else begin
            click_q  <= click_d;
            change_q <= change_d;
        end
    end

    // ------------------------------------------------------------------
    // Auto-repeat FSM per button. Decisions use the next debounced level
    // so a release on the same edge as an expiry suppresses the pulse.
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] repeat_w;

    for (genvar gb = 0; gb < N_BTN; gb++) begin : g_rep
        rep_state_t      state_q, state_d;
        logic [RC_W-1:0] rcnt_q, rcnt_d;
        logic            rep_q, rep_d;

        // Next state, counter and pulse for this button
        always_comb begin
            state_d = state_q;
            rcnt_d  = rcnt_q;
            rep_d   = 1'b0;
            if (!lvl_next_w[gb]) begin
                state_d = ST_IDLE;
                rcnt_d  = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (!lvl_now_w[gb]) begin
                            rep_d   = 1'b1;
                            rcnt_d  = '0;
                            state_d = ST_DELAY;
                        end
                    end
                    ST_DELAY: begin
                        if (rcnt_q == RD_LAST) begin
                            rep_d   = 1'b1;
                            rcnt_d  = '0;
                            state_d = ST_PERIOD;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                    ST_PERIOD: begin
                        if (rcnt_q == RP_LAST) begin
                            rep_d  = 1'b1;
                            rcnt_d = '0;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        rcnt_d  = '0;
                    end
                endcase
            end
        end

        // Repeat FSM state register
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                state_q <= ST_IDLE;
                rcnt_q  <= '0;
                rep_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                rcnt_q  <= rcnt_d;
                rep_q   <= rep_d;
            end
        end

        assign repeat_w[gb] = rep_q;
    end

    assign pin.BTN_LEVEL  = lvl_now_w;
    assign pin.BTN_CLICK  = click_q;
    assign pin.BTN_REPEAT = repeat_w;
    assign pin.SW_STATE   = sw_now_w;
    assign pin.SW_CHANGE  = change_q;

endmodule
`default_nettype wire

// File: tb/tb_panel_input.sv
`default_nettype none
// ============================================================================
// Module      : tb_panel_input
// Description : Directed self-checking bench for panel_input with short
//               debounce/repeat parameters.
// Revision    : 1.0  initial release
// ============================================================================
module tb_panel_input;

    logic CLK  = 1'b0;
    logic RSTN = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    panel_input_if pif ();

    panel_input #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .pin  (pif)
    );

    always #5 CLK = ~CLK;

    // Global time bound
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Expected repeat pulse at offset o from the click, while still held
    function automatic logic sched(input int o, input int stop);
        if (o >= stop) return 1'b0;
        if (o == 0) return 1'b1;
        if (o >= 10 && ((o - 10) % 3) == 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic test_reset();
        RSTN = 1'b0;
        pif.BTN = '0;
        pif.SW  = '0;
        step(2);
        n_checks++; if (pif.BTN_LEVEL !== 5'h00) $display("FAIL reset_level got %h want 00", pif.BTN_LEVEL); else n_pass++;
        n_checks++; if (pif.BTN_CLICK !== 5'h00 || pif.BTN_REPEAT !== 5'h00) $display("FAIL reset_pulses got %h/%h want 00/00", pif.BTN_CLICK, pif.BTN_REPEAT); else n_pass++;
        n_checks++; if (pif.SW_STATE !== 16'h0000 || pif.SW_CHANGE !== 1'b0) $display("FAIL reset_sw got %h/%b want 0000/0", pif.SW_STATE, pif.SW_CHANGE); else n_pass++;
        RSTN = 1'b1;
        step(3);
    endtask

    task automatic test_click();
        int clicks;
        pif.BTN[2] = 1'b1;            // first sampled at next edge (edge 1)
        step(5);                      // after edge 5
        n_checks++; if (pif.BTN_LEVEL[2] !== 1'b0 || pif.BTN_CLICK[2] !== 1'b0) $display("FAIL click_early got lvl=%b clk=%b want 0/0", pif.BTN_LEVEL[2], pif.BTN_CLICK[2]); else n_pass++;
        step(1);                      // after edge 6
        n_checks++; if (pif.BTN_LEVEL !== 5'b00100) $display("FAIL click_level got %b want 00100", pif.BTN_LEVEL); else n_pass++;
        n_checks++; if (pif.BTN_CLICK !== 5'b00100 || pif.BTN_REPEAT !== 5'b00100) $display("FAIL click_pulse got %b/%b want 00100/00100", pif.BTN_CLICK, pif.BTN_REPEAT); else n_pass++;
        step(1);
        n_checks++; if (pif.BTN_CLICK[2] !== 1'b0 || pif.BTN_REPEAT[2] !== 1'b0) $display("FAIL click_width got %b/%b want 0/0", pif.BTN_CLICK[2], pif.BTN_REPEAT[2]); else n_pass++;
        pif.BTN[2] = 1'b0;
        clicks = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            clicks += int'(pif.BTN_CLICK[2]) + int'(pif.BTN_REPEAT[2]);
        end
        n_checks++; if (clicks !== 0 || pif.BTN_LEVEL[2] !== 1'b0) $display("FAIL click_release got pulses=%0d lvl=%b want 0/0", clicks, pif.BTN_LEVEL[2]); else n_pass++;
    endtask

    task automatic test_bounce();
        logic [7:0] pat;
        int clicks, glitch;
        pat = 8'b00110011;            // LSB first: 1,1,0,0,1,1,0,0
        clicks = 0;
        for (int i = 0; i < 8; i++) begin
            pif.BTN[0] = pat[i];
            step(1);
            clicks += int'(pif.BTN_CLICK[0]);
        end
        pif.BTN[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            clicks += int'(pif.BTN_CLICK[0]);
        end
        n_checks++; if (clicks !== 1) $display("FAIL bounce_clicks got %0d want 1", clicks); else n_pass++;
        n_checks++; if (pif.BTN_LEVEL[0] !== 1'b1) $display("FAIL bounce_level got %b want 1", pif.BTN_LEVEL[0]); else n_pass++;
        pif.BTN[0] = 1'b0;
        step(12);
        glitch = 0;
        pif.BTN[4] = 1'b1;
        step(3);
        pif.BTN[4] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            glitch += int'(pif.BTN_LEVEL[4]) + int'(pif.BTN_CLICK[4]) + int'(pif.BTN_REPEAT[4]);
        end
        n_checks++; if (glitch !== 0) $display("FAIL glitch_reject got %0d events want 0", glitch); else n_pass++;
        n_checks++; if (pif.BTN_LEVEL !== 5'b00000) $display("FAIL bounce_idle got %b want 00000", pif.BTN_LEVEL); else n_pass++;
    endtask

    task automatic test_repeat();
        int  guard;
        int  bad, quiet;
        logic exp_rep;
        pif.BTN[3] = 1'b1;
        guard = 0;
        while (pif.BTN_CLICK[3] !== 1'b1 && guard < 20) begin
            step(1);
            guard++;
        end
        n_checks++; if (guard >= 20) $display("FAIL repeat_click_timeout got none want click"); else n_pass++;
        // Offset 0 is the click cycle; release is set after offset 31 and
        // its debounced fall (offset 37) collides with a period expiry.
        bad = 0;
        for (int o = 0; o <= 45; o++) begin
            if (o > 0) step(1);
            if (o == 31) pif.BTN[3] = 1'b0;
            exp_rep = sched(o, 37);
            n_checks++;
            if (pif.BTN_REPEAT[3] !== exp_rep) begin
                $display("FAIL repeat_sched offset=%0d got %b want %b", o, pif.BTN_REPEAT[3], exp_rep);
                bad++;
            end else n_pass++;
            if (o == 36) begin
                n_checks++; if (pif.BTN_LEVEL[3] !== 1'b1) $display("FAIL repeat_hold_level got %b want 1", pif.BTN_LEVEL[3]); else n_pass++;
            end
            if (o == 37) begin
                n_checks++; if (pif.BTN_LEVEL[3] !== 1'b0) $display("FAIL repeat_release_level got %b want 0", pif.BTN_LEVEL[3]); else n_pass++;
            end
        end
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            quiet += int'(pif.BTN_CLICK[3]) + int'(pif.BTN_REPEAT[3]);
        end
        n_checks++; if (quiet !== 0) $display("FAIL repeat_after_release got %0d pulses want 0", quiet); else n_pass++;
    endtask

    task automatic test_switch();
        int changes;
        pif.SW = 16'h8001;
        step(5);
        n_checks++; if (pif.SW_STATE !== 16'h0000 || pif.SW_CHANGE !== 1'b0) $display("FAIL sw_early got %h/%b want 0000/0", pif.SW_STATE, pif.SW_CHANGE); else n_pass++;
        step(1);
        n_checks++; if (pif.SW_STATE !== 16'h8001) $display("FAIL sw_state got %h want 8001", pif.SW_STATE); else n_pass++;
        n_checks++; if (pif.SW_CHANGE !== 1'b1) $display("FAIL sw_change got %b want 1", pif.SW_CHANGE); else n_pass++;
        step(1);
        n_checks++; if (pif.SW_CHANGE !== 1'b0 || pif.SW_STATE !== 16'h8001) $display("FAIL sw_change_width got %b/%h want 0/8001", pif.SW_CHANGE, pif.SW_STATE); else n_pass++;
        pif.SW = 16'h0000;
        changes = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            changes += int'(pif.SW_CHANGE);
        end
        n_checks++; if (changes !== 1 || pif.SW_STATE !== 16'h0000) $display("FAIL sw_return got %0d/%h want 1/0000", changes, pif.SW_STATE); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int guard, early;
        pif.BTN[1] = 1'b1;
        guard = 0;
        while (pif.BTN_CLICK[1] !== 1'b1 && guard < 20) begin
            step(1);
            guard++;
        end
        n_checks++; if (guard >= 20) $display("FAIL rst_mid_click_timeout got none want click"); else n_pass++;
        step(4);                      // mid delay phase
        RSTN = 1'b0;
        #1;
        n_checks++; if (pif.BTN_LEVEL !== 5'h00 || pif.BTN_CLICK !== 5'h00 || pif.BTN_REPEAT !== 5'h00) $display("FAIL rst_mid_outputs got %b/%b/%b want 0", pif.BTN_LEVEL, pif.BTN_CLICK, pif.BTN_REPEAT); else n_pass++;
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        step(5);
        n_checks++; if (pif.BTN_LEVEL[1] !== 1'b0 || pif.BTN_CLICK[1] !== 1'b0) $display("FAIL rst_mid_latency got %b/%b want 0/0", pif.BTN_LEVEL[1], pif.BTN_CLICK[1]); else n_pass++;
        step(1);
        n_checks++; if (pif.BTN_CLICK[1] !== 1'b1 || pif.BTN_REPEAT[1] !== 1'b1) $display("FAIL rst_mid_reclick got %b/%b want 1/1", pif.BTN_CLICK[1], pif.BTN_REPEAT[1]); else n_pass++;
        early = 0;
        for (int o = 1; o <= 9; o++) begin
            step(1);
            early += int'(pif.BTN_REPEAT[1]);
        end
        n_checks++; if (early !== 0) $display("FAIL rst_mid_no_early got %0d want 0", early); else n_pass++;
        step(1);
        n_checks++; if (pif.BTN_REPEAT[1] !== 1'b1) $display("FAIL rst_mid_first_repeat got %b want 1", pif.BTN_REPEAT[1]); else n_pass++;
        pif.BTN[1] = 1'b0;
        step(12);
    endtask

    task automatic test_simultaneous();
        int guard;
        logic exp_rep;
        pif.BTN[1] = 1'b1;
        pif.BTN[3] = 1'b1;
        guard = 0;
        while (pif.BTN_CLICK[1] !== 1'b1 && guard < 20) begin
            step(1);
            guard++;
        end
        n_checks++; if (guard >= 20) $display("FAIL simul_click_timeout got none want click"); else n_pass++;
        n_checks++; if (pif.BTN_CLICK !== 5'b01010) $display("FAIL simul_click got %b want 01010", pif.BTN_CLICK); else n_pass++;
        for (int o = 0; o <= 20; o++) begin
            if (o > 0) step(1);
            exp_rep = sched(o, 1000);
            n_checks++;
            if (pif.BTN_REPEAT !== {1'b0, exp_rep, 1'b0, exp_rep, 1'b0})
                $display("FAIL simul_repeat offset=%0d got %b want %b", o, pif.BTN_REPEAT, {1'b0, exp_rep, 1'b0, exp_rep, 1'b0});
            else n_pass++;
        end
        pif.BTN[1] = 1'b0;
        pif.BTN[3] = 1'b0;
        step(10);
        n_checks++; if (pif.BTN_LEVEL !== 5'b00000) $display("FAIL simul_release got %b want 00000", pif.BTN_LEVEL); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_click();
        test_bounce();
        test_repeat();
        test_switch();
        test_reset_mid();
        test_simultaneous();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
